disp_src_arbiter: RTL and testbench
===================================

// Module: disp_src_arbiter
// PURPOSE
// - Shares the 4-digit 7-segment display between 3 requesting sources (e.g. clock, stopwatch, alarm).
// - Grants one source at a time, round-robin, with a minimum dwell time and a blank gap between owners.
// - Drives digit3..digit0 of the scan controller with registered BCD/hex nibbles.
// - Sits between the application datapaths and the scan controller / display decoder.
// PARAMETERS
// - DWELL_CYC   50_000_000  clocks a granted source keeps the display before yielding to another requester (>=2)
// - GAP_CYC     1_000_000   clocks of blank display between two owners; 0 = no gap state
// - BLANK_CODE  4'hF        nibble driven on all digits when no source owns the display
// PORTS
// - clk          in   1   system clock, all logic on rising edge
// - rst_n        in   1   asynchronous active-low reset
// - req          in   3   req[i]=1: source i wants the display; level, may drop any cycle
// - data0        in   16  source 0 digits {d3,d2,d1,d0}, nibble each
// - data1        in   16  source 1 digits
// - data2        in   16  source 2 digits
// - digit3       out  4   leftmost digit to scan controller (registered)
// - digit2       out  4   registered
// - digit1       out  4   registered
// - digit0       out  4   rightmost digit (registered)
// - gnt          out  3   one-hot owner; 3'b000 in IDLE/GAP (registered)
// - new_owner    out  1   1-cycle pulse on the first cycle of every grant
// BEHAVIOUR
// - Reset: state=IDLE, gnt=0, new_owner=0, all digits=BLANK_CODE, cnt=0, last=2 (first search starts at src 0).
// - RR pick: first i with req[i]=1 in order last+1, last+2, last (mod 3); last = index of most recent grant.
// - IDLE: digits=BLANK. If |req at edge N -> SHOW at N+1: gnt, last, new_owner=1, digits=data of winner, cnt=0.
// - SHOW: each cycle digits <= data of granted src (live tracking, 1-cycle latency); cnt++.
// - SHOW exit, owner drops req: next cycle -> GAP (GAP_CYC>0) else direct RR pick / IDLE; gnt=0 that cycle.
// - SHOW dwell: at cnt==DWELL_CYC-1, if any other src requests -> GAP (or direct switch if GAP_CYC=0);
//   else cnt<=0, stay in SHOW with same owner, no new_owner pulse.
// - Drop and dwell expiry in same cycle: handled as drop.
// - GAP: gnt=0, digits=BLANK, cnt counts 0..GAP_CYC-1; at last count pick RR winner from req sampled then
//   -> SHOW (new_owner=1), or IDLE if req==0. Requests that drop during GAP are not remembered.
// - Previous owner re-requesting is eligible but lowest priority (RR order).
// - GAP_CYC=0: SHOW->SHOW switch in one edge; new owner data on digits next cycle, gnt changes directly.
// - cnt width = $clog2(max(DWELL_CYC,GAP_CYC)); cnt cleared on every state entry; no wrap beyond terminal.
// - Unknown/illegal state encoding -> IDLE on next edge.
// - rst_n low mid-SHOW/GAP: outputs return to reset values asynchronously; RR pointer back to last=2.
// STRUCTURE
// - Shared header disp_arb_defs.vh: state codes IDLE/SHOW/GAP (2-bit), NUM_SRC=3, default BLANK_CODE.
// - Sub-module rr_pick3 (combinational): inputs req[2:0], last[1:0]; outputs valid, idx[1:0].
// - Top: 3-state FSM, shared cnt, last register, 16-bit data mux -> digit registers.
// TESTING (sim with DWELL_CYC=8, GAP_CYC=2, BLANK_CODE=4'hF)
// - Reset then req=3'b000 for 20 clk -> digits=FFFF, gnt=000, new_owner never 1.
// - req=3'b010, data1=16'h1234 at edge N -> gnt=010, new_owner=1 at N+1; digits 1,2,3,4 from N+1;
//   holds indefinitely, no pulse at dwell expiry.
// - req=3'b111 constant -> grant order 001,010,100,001...; each SHOW 8 clk, 2 clk blank FFFF between.
// - Owner 0 drops req at SHOW cnt=3 while req[2]=1 -> next cycle gnt=000/FFFF for 2 clk, then gnt=100.
// - Drop and dwell expiry same edge, req=0 else -> GAP 2 clk then IDLE, digits FFFF, gnt=000.
// - Assert rst_n=0 mid-GAP -> immediate FFFF/000; after release, req=3'b111 -> first gnt=001.

Source files
------------

// File: rtl/disp_src_arbiter_pkg.sv
// Shared definitions for the display source arbiter: state codes, source count, blank nibble.
package disp_src_arbiter_pkg;

  localparam int unsigned NumSrc = 3;
  localparam logic [3:0] BlankCodeDefault = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StGap  = 2'd2
  } state_e;

  function automatic logic [NumSrc-1:0] src_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/disp_src_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters; the previous winner is searched last.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  logic [1:0] first, second;

  always_comb begin
    first  = inc3(last);
    second = inc3(first);
    valid  = |req;
    if (req[first]) begin
      idx = first;
    end else if (req[second]) begin
      idx = second;
    end else begin
      idx = last;
    end
  end

endmodule

// File: rtl/disp_src_arbiter.sv
// Shares one 4-digit display among three sources: round-robin grant, minimum dwell, blank gap.
module disp_src_arbiter
  import disp_src_arbiter_pkg::*;
#(
  parameter int unsigned DWELL_CYC  = 50_000_000,
  parameter int unsigned GAP_CYC    = 1_000_000,
  parameter logic [3:0]  BLANK_CODE = BlankCodeDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [2:0]  gnt,
  output logic        new_owner
);

  localparam int unsigned MaxCyc = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
  localparam int unsigned CntW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYC - 1);
  localparam logic [CntW-1:0] GapLast = (GAP_CYC > 0) ? CntW'(GAP_CYC - 1) : '0;
  localparam logic [15:0] BlankAll = {4{BLANK_CODE}};

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      last_q;
  logic [15:0]     disp_q;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [15:0] owner_data, pick_data;
  logic        owner_req, others_req, leave_show;

  function automatic logic [15:0] src_mux(input logic [1:0] sel, input logic [15:0] d0,
                                          input logic [15:0] d1, input logic [15:0] d2);
    case (sel)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_data = src_mux(last_q, data0, data1, data2);
    pick_data  = src_mux(pick_idx, data0, data1, data2);
    owner_req  = req[last_q];
    others_req = |(req & ~gnt);
    // A drop wins over dwell expiry; both leave SHOW the same way.
    leave_show = !owner_req || (cnt_q == DwellLast && others_req);
  end

  assign {digit3, digit2, digit1, digit0} = disp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 2'd2;
      gnt       <= '0;
      new_owner <= 1'b0;
      disp_q    <= BlankAll;
    end else begin
      new_owner <= 1'b0;
      case (state_q)
        StShow: begin
          if (leave_show && GAP_CYC != 0) begin
            state_q <= StGap;
            cnt_q   <= '0;
            gnt     <= '0;
            disp_q  <= BlankAll;
          end else if (leave_show && pick_valid) begin
            state_q   <= StShow;
            cnt_q     <= '0;
            gnt       <= src_onehot(pick_idx);
            last_q    <= pick_idx;
            new_owner <= 1'b1;
            disp_q    <= pick_data;
          end else if (leave_show) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gnt     <= '0;
            disp_q  <= BlankAll;
          end else begin
            cnt_q  <= (cnt_q == DwellLast) ? '0 : cnt_q + 1'b1;
            disp_q <= owner_data;
          end
        end
        StIdle, StGap: begin
          gnt    <= '0;
          disp_q <= BlankAll;
          if (state_q == StGap && cnt_q != GapLast) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (pick_valid) begin
            state_q   <= StShow;
            cnt_q     <= '0;
            gnt       <= src_onehot(pick_idx);
            last_q    <= pick_idx;
            new_owner <= 1'b1;
            disp_q    <= pick_data;
          end else begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          gnt     <= '0;
          disp_q  <= BlankAll;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Directed bench for disp_src_arbiter with DWELL_CYC=8, GAP_CYC=2, BLANK_CODE=F.
module tb_disp_src_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] data0 = 16'hABCD;
  logic [15:0] data1 = 16'h1234;
  logic [15:0] data2 = 16'h5678;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic [2:0]  gnt;
  logic        new_owner;

  int n_cmp = 0;
  int n_fail = 0;

  disp_src_arbiter #(
    .DWELL_CYC  (8),
    .GAP_CYC    (2),
    .BLANK_CODE (4'hF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0),
    .gnt       (gnt),
    .new_owner (new_owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] egnt, input logic enew,
                            input logic [15:0] edig);
    chk({tag, ".gnt"}, {13'b0, gnt}, {13'b0, egnt});
    chk({tag, ".new_owner"}, {15'b0, new_owner}, {15'b0, enew});
    chk({tag, ".digits"}, {digit3, digit2, digit1, digit0}, edig);
  endtask

  initial begin
    logic [15:0] exp_dig;
    logic [2:0]  exp_gnt;
    int          idx;

    // Reset and idle
    step();
    step();
    expect_out("reset", 3'b000, 1'b0, 16'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("idle", 3'b000, 1'b0, 16'hFFFF);
    end

    // Lone requester 1 holds across dwell expiries with live data tracking
    req = 3'b010;
    step();
    expect_out("grant1", 3'b010, 1'b1, 16'h1234);
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("hold1", 3'b010, 1'b0, 16'h1234);
    end
    data1 = 16'h9876;
    step();
    chk("track1", {digit3, digit2, digit1, digit0}, 16'h9876);
    data1 = 16'h1234;
    req = 3'b000;
    step();
    expect_out("drop1.gap0", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("drop1.gap1", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("drop1.idle", 3'b000, 1'b0, 16'hFFFF);

    // Drop coinciding with dwell expiry: gap then idle
    req = 3'b010;
    step();
    expect_out("grant1b", 3'b010, 1'b1, 16'h1234);
    repeat (7) step();
    expect_out("cnt7", 3'b010, 1'b0, 16'h1234);
    req = 3'b000;
    step();
    expect_out("dropexp.gap0", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("dropexp.gap1", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("dropexp.idle", 3'b000, 1'b0, 16'hFFFF);

    // Owner 0 drops at cnt=3 while source 2 waits
    req = 3'b001;
    step();
    expect_out("grant0", 3'b001, 1'b1, 16'hABCD);
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("show0", 3'b001, 1'b0, 16'hABCD);
    end
    req = 3'b100;
    step();
    expect_out("drop0.gap0", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("drop0.gap1", 3'b000, 1'b0, 16'hFFFF);
    step();
    expect_out("grant2", 3'b100, 1'b1, 16'h5678);

    // Move pointer to 1, then reset mid-gap
    req = 3'b000;
    repeat (3) step();
    expect_out("idle2", 3'b000, 1'b0, 16'hFFFF);
    req = 3'b010;
    step();
    expect_out("grant1c", 3'b010, 1'b1, 16'h1234);
    req = 3'b000;
    step();
    expect_out("gap_pre_rst", 3'b000, 1'b0, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1 expect_out("rst_gap", 3'b000, 1'b0, 16'hFFFF);
    #2 rst_n = 1'b1;
    req = 3'b111;

    // All three requesting: 8 cycles per owner, 2 blank cycles between
    for (int k = 0; k < 32; k++) begin
      step();
      idx = (k / 10) % 3;
      if (k % 10 < 8) begin
        exp_gnt = 3'b001 << idx;
        exp_dig = (idx == 0) ? 16'hABCD : (idx == 1) ? 16'h1234 : 16'h5678;
      end else begin
        exp_gnt = 3'b000;
        exp_dig = 16'hFFFF;
      end
      expect_out($sformatf("rr%0d", k), exp_gnt, (k % 10 == 0), exp_dig);
    end

    // Asynchronous reset while showing
    #2 rst_n = 1'b0;
    #1 expect_out("rst_show", 3'b000, 1'b0, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
